pkt_capture_ctrl: RTL and testbench

Packet capture sequencer between the 14-bit ADC sample stream and the preprocessing datapath output. It is armed by a software start, waits for a trigger, then frames a configured number of samples into a packet (valid/last/ready stream). It repeats for a configured packet count, with a programmable idle gap between packets. It reports busy, done, packet count and sticky overflow to the AXI-Lite register block.

---
 rtl/pkt_capture_pkg.sv | 19 +
 rtl/pkt_capture_ctrl_if.sv | 32 +++
 rtl/pkt_out_reg.sv | 50 +++++
 rtl/pkt_capture_ctrl.sv | 157 +++++++++++++++
 tb/tb_pkt_capture_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_capture_pkg.sv
// Shared widths and FSM state encoding for the packet capture sequencer.
// State values are plain constants so legacy register maps can decode them.
package pkt_capture_pkg;

  localparam int DEF_ADC_WIDTH = 14;
  localparam int DEF_LEN_WIDTH = 16;
  localparam int DEF_NUM_WIDTH = 8;
  localparam int DEF_GAP_WIDTH = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARMED   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_GAP     = 3'd3;
  localparam state_t ST_DRAIN   = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/pkt_capture_ctrl_if.sv
// Sample input strobe and packet output stream of the capture sequencer.
// The master side is the sequencer; the slave side is the ADC and downstream sink.
interface pkt_capture_ctrl_if #(
  parameter int ADC_WIDTH = pkt_capture_pkg::DEF_ADC_WIDTH
) ();

  logic                 s_valid_i;
  logic [ADC_WIDTH-1:0] s_data_i;
  logic [ADC_WIDTH-1:0] m_data_o;
  logic                 m_valid_o;
  logic                 m_last_o;
  logic                 m_ready_i;

  modport master (
    input  s_valid_i,
    input  s_data_i,
    input  m_ready_i,
    output m_data_o,
    output m_valid_o,
    output m_last_o
  );

  modport slave (
    output s_valid_i,
    output s_data_i,
    output m_ready_i,
    input  m_data_o,
    input  m_valid_o,
    input  m_last_o
  );

endinterface

// File: rtl/pkt_out_reg.sv
// Single-entry valid/ready output register carrying a sample and its last flag.
// drained is high when the slot is empty or is being emptied this cycle.
module pkt_out_reg #(
  parameter int DATA_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  last_in,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  last,
  output logic                  drained
);

  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  last_r;

  assign data    = data_r;
  assign valid   = valid_r;
  assign last    = last_r;
  assign drained = !valid_r || ready;

  // Slot update: flush beats load, load beats plain drain; data holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= {DATA_WIDTH{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (accept) begin
      data_r  <= data_in;
      last_r  <= last_in;
      valid_r <= 1'b1;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      valid_r <= valid_r;
      last_r  <= last_r;
    end
  end

endmodule

// File: rtl/pkt_capture_ctrl.sv
// Packet capture sequencer: arm on start, wait for trigger, frame ADC samples
// into fixed-length packets with an idle gap, and report status upward.
module pkt_capture_ctrl import pkt_capture_pkg::*; #(
  parameter int ADC_WIDTH = DEF_ADC_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int NUM_WIDTH = DEF_NUM_WIDTH,
  parameter int GAP_WIDTH = DEF_GAP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 trig_i,
  input  logic [LEN_WIDTH-1:0] cfg_pkt_len_i,
  input  logic [NUM_WIDTH-1:0] cfg_pkt_num_i,
  input  logic [GAP_WIDTH-1:0] cfg_gap_i,
  pkt_capture_ctrl_if.master   stream,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ovf_o,
  output logic [NUM_WIDTH-1:0] pkt_cnt_o
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_WIDTH-1:0] NUM_ZERO = {NUM_WIDTH{1'b0}};
  localparam logic [NUM_WIDTH-1:0] NUM_ONE  = {{(NUM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0] GAP_ZERO = {GAP_WIDTH{1'b0}};
  localparam logic [GAP_WIDTH-1:0] GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_nxt_s;
  logic [LEN_WIDTH-1:0] len_r;
  logic [NUM_WIDTH-1:0] num_r;
  logic [GAP_WIDTH-1:0] gap_r;
  logic [LEN_WIDTH-1:0] smp_cnt_r;
  logic [GAP_WIDTH-1:0] gap_cnt_r;
  logic [NUM_WIDTH-1:0] pkt_cnt_r;
  logic                 ovf_r;
  logic                 busy_r;
  logic                 done_r;

  logic start_ok_s;
  logic in_capture_s;
  logic drained_s;
  logic accept_s;
  logic drop_s;
  logic last_s;
  logic final_pkt_s;
  logic gap_end_s;

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign ovf_o     = ovf_r;
  assign pkt_cnt_o = pkt_cnt_r;

  // Sample acceptance, drop detection and packet/gap boundary decode.
  always_comb begin
    start_ok_s   = start_i && (cfg_pkt_len_i != LEN_ZERO) && (cfg_pkt_num_i != NUM_ZERO);
    in_capture_s = (state_r == ST_CAPTURE) && !abort_i;
    accept_s     = in_capture_s && stream.s_valid_i && drained_s;
    drop_s       = in_capture_s && stream.s_valid_i && !drained_s;
    last_s       = (smp_cnt_r + LEN_ONE) == len_r;
    final_pkt_s  = (pkt_cnt_r + NUM_ONE) == num_r;
    gap_end_s    = gap_cnt_r == (gap_r - GAP_ONE);
  end

  // Next-state selection; abort overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = start_ok_s ? ST_ARMED : ST_IDLE;
        ST_ARMED:   state_nxt_s = trig_i ? ST_CAPTURE : ST_ARMED;
        ST_CAPTURE: begin
          if (accept_s && last_s) begin
            if (final_pkt_s) begin
              state_nxt_s = ST_DRAIN;
            end else if (gap_r != GAP_ZERO) begin
              state_nxt_s = ST_GAP;
            end else begin
              state_nxt_s = ST_ARMED;
            end
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        ST_GAP:     state_nxt_s = gap_end_s ? ST_ARMED : ST_GAP;
        ST_DRAIN:   state_nxt_s = drained_s ? ST_DONE : ST_DRAIN;
        ST_DONE:    state_nxt_s = ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, latched configuration, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      len_r     <= LEN_ZERO;
      num_r     <= NUM_ZERO;
      gap_r     <= GAP_ZERO;
      smp_cnt_r <= LEN_ZERO;
      gap_cnt_r <= GAP_ZERO;
      pkt_cnt_r <= NUM_ZERO;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= state_nxt_s != ST_IDLE;
      done_r  <= state_nxt_s == ST_DONE;
      if ((state_r == ST_IDLE) && start_ok_s && !abort_i) begin
        len_r     <= cfg_pkt_len_i;
        num_r     <= cfg_pkt_num_i;
        gap_r     <= cfg_gap_i;
        smp_cnt_r <= LEN_ZERO;
        gap_cnt_r <= GAP_ZERO;
        pkt_cnt_r <= NUM_ZERO;
        ovf_r     <= 1'b0;
      end else begin
        if (drop_s) begin
          ovf_r <= 1'b1;
        end
        if (accept_s) begin
          if (last_s) begin
            smp_cnt_r <= LEN_ZERO;
            pkt_cnt_r <= pkt_cnt_r + NUM_ONE;
          end else begin
            smp_cnt_r <= smp_cnt_r + LEN_ONE;
          end
        end
        // The gap counter only runs while idling between packets.
        gap_cnt_r <= (state_r == ST_GAP) ? (gap_cnt_r + GAP_ONE) : GAP_ZERO;
      end
    end
  end

  pkt_out_reg #(
    .DATA_WIDTH (ADC_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept_s),
    .flush   (abort_i),
    .data_in (stream.s_data_i),
    .last_in (last_s),
    .ready   (stream.m_ready_i),
    .data    (stream.m_data_o),
    .valid   (stream.m_valid_o),
    .last    (stream.m_last_o),
    .drained (drained_s)
  );

endmodule

// File: tb/tb_pkt_capture_ctrl.sv
// Randomised bench for pkt_capture_ctrl: a run-level reference model predicts
// status and the accepted sample sequence; a monitor pops it on every transfer.
module tb_pkt_capture_ctrl;

  localparam int AW = 14;
  localparam int LW = 16;
  localparam int NW = 8;
  localparam int GW = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_TAKE  = 2;
  localparam int PH_GAP   = 3;
  localparam int PH_DRAIN = 4;
  localparam int PH_DONE  = 5;

  typedef struct packed {
    logic [AW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic          trig_i;
  logic [LW-1:0] cfg_pkt_len_i;
  logic [NW-1:0] cfg_pkt_num_i;
  logic [GW-1:0] cfg_gap_i;
  logic          busy_o;
  logic          done_o;
  logic          ovf_o;
  logic [NW-1:0] pkt_cnt_o;

  pkt_capture_ctrl_if #(.ADC_WIDTH(AW)) pif ();

  pkt_capture_ctrl #(
    .ADC_WIDTH(AW), .LEN_WIDTH(LW), .NUM_WIDTH(NW), .GAP_WIDTH(GW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .trig_i        (trig_i),
    .cfg_pkt_len_i (cfg_pkt_len_i),
    .cfg_pkt_num_i (cfg_pkt_num_i),
    .cfg_gap_i     (cfg_gap_i),
    .stream        (pif.master),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .ovf_o         (ovf_o),
    .pkt_cnt_o     (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  int   n_out, n_last, n_done;
  int   cyc_n = 0;
  bit   strobe_rand, ready_rand, trig_rand, ready_lvl;

  // Reference model: run-level view, counting down what is left to do.
  int   m_phase, m_pkts, m_left, m_pkts_left, m_gap_left;
  int   l_len, l_num, l_gap;
  bit   m_full, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   room;
    exp_t e;
    if (rst) begin
      m_phase = PH_IDLE; m_full = 1'b0; m_ovf = 1'b0; m_pkts = 0;
      expq.delete();
    end else if (abort_i) begin
      m_phase = PH_IDLE; m_full = 1'b0;
      expq.delete();
    end else begin
      room = !m_full || pif.m_ready_i;
      if (m_full && pif.m_ready_i) m_full = 1'b0;
      case (m_phase)
        PH_IDLE: if (start_i && cfg_pkt_len_i != 0 && cfg_pkt_num_i != 0) begin
          l_len = int'(cfg_pkt_len_i); l_num = int'(cfg_pkt_num_i); l_gap = int'(cfg_gap_i);
          m_left = l_len; m_pkts_left = l_num; m_pkts = 0; m_ovf = 1'b0;
          m_phase = PH_WAIT;
        end
        PH_WAIT: if (trig_i) m_phase = PH_TAKE;
        PH_TAKE: if (pif.s_valid_i) begin
          if (room) begin
            m_full = 1'b1;
            e.d = pif.s_data_i;
            e.l = (m_left == 1);
            expq.push_back(e);
            m_left--;
            if (m_left == 0) begin
              m_pkts++; m_pkts_left--; m_left = l_len;
              if (m_pkts_left == 0) m_phase = PH_DRAIN;
              else if (l_gap != 0) begin m_gap_left = l_gap; m_phase = PH_GAP; end
              else m_phase = PH_WAIT;
            end
          end else begin
            m_ovf = 1'b1;
          end
        end
        PH_GAP: begin
          m_gap_left--;
          if (m_gap_left == 0) m_phase = PH_WAIT;
        end
        PH_DRAIN: if (room) m_phase = PH_DONE;
        PH_DONE:  m_phase = PH_IDLE;
        default:  m_phase = PH_IDLE;
      endcase
    end
  endtask

  // One clock: drive stream inputs, let the edge happen, advance the model.
  task automatic cyc(input bit st, input bit ab);
    start_i = st;
    abort_i = ab;
    cyc_n++;
    pif.s_valid_i = strobe_rand ? ($urandom_range(0, 2) == 0) : (cyc_n % 3 == 0);
    pif.s_data_i  = AW'($urandom_range(0, 16383));
    pif.m_ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_lvl;
    if (trig_rand) trig_i = ($urandom_range(0, 3) == 0);
    @(posedge clk);
    #1;
    model_step();
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int bound);
    int k;
    k = 0;
    while (!done_o && k < bound) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done within %0d cycles", name, bound);
    end
  endtask

  task automatic set_cfg(input int len, input int num, input int gap);
    cfg_pkt_len_i = LW'(len);
    cfg_pkt_num_i = NW'(num);
    cfg_gap_i     = GW'(gap);
  endtask

  task automatic clear_stats();
    n_out = 0; n_last = 0; n_done = 0;
  endtask

  // Monitor: status against the model every cycle, samples on each transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      check("m_valid", int'(pif.m_valid_o), int'(m_full));
      check("busy", int'(busy_o), int'(m_phase != PH_IDLE));
      check("done", int'(done_o), int'(m_phase == PH_DONE));
      check("ovf", int'(ovf_o), int'(m_ovf));
      check("pkt_cnt", int'(pkt_cnt_o), m_pkts);
      if (pif.m_valid_o && pif.m_ready_i) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=data %0d expected=no transfer", pif.m_data_o);
        end else begin
          mon_e = expq.pop_front();
          check("data", int'(pif.m_data_o), int'(mon_e.d));
          check("last", int'(pif.m_last_o), int'(mon_e.l));
          n_out++;
          if (pif.m_last_o) n_last++;
        end
      end
      if (done_o) n_done++;
    end
  end

  initial begin
    int k;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0;
    set_cfg(0, 0, 0);
    strobe_rand = 1'b0; ready_rand = 1'b0; trig_rand = 1'b0; ready_lvl = 1'b1;
    pif.s_valid_i = 1'b0; pif.s_data_i = '0; pif.m_ready_i = 1'b1;
    clear_stats();
    m_phase = PH_IDLE; m_full = 1'b0; m_ovf = 1'b0; m_pkts = 0;

    cyc(1'b0, 1'b0);
    mon_en = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    check("rst_data", int'(pif.m_data_o), 0);
    check("rst_last", int'(pif.m_last_o), 0);
    check("rst_busy", int'(busy_o), 0);

    // Nominal run
    set_cfg(8, 3, 10); trig_i = 1'b1; clear_stats();
    cyc(1'b1, 1'b0);
    run_until_done("nominal", 1000);
    repeat (3) cyc(1'b0, 1'b0);
    check("nom_outputs", n_out, 24);
    check("nom_lasts", n_last, 3);
    check("nom_done", n_done, 1);
    check("nom_pkt_cnt", int'(pkt_cnt_o), 3);
    check("nom_ovf", int'(ovf_o), 0);

    // Trigger gating
    set_cfg(4, 1, 0); trig_i = 1'b0; clear_stats();
    cyc(1'b1, 1'b0);
    repeat (100) cyc(1'b0, 1'b0);
    check("gate_no_out", n_out, 0);
    check("gate_busy", int'(busy_o), 1);
    trig_i = 1'b1;
    run_until_done("gate", 300);
    repeat (2) cyc(1'b0, 1'b0);
    check("gate_outputs", n_out, 4);

    // Backpressure
    set_cfg(4, 1, 0); clear_stats();
    cyc(1'b1, 1'b0);
    k = 0;
    while (!pif.m_valid_o && k < 100) begin cyc(1'b0, 1'b0); k++; end
    ready_lvl = 1'b0;
    repeat (7) cyc(1'b0, 1'b0);
    check("bp_ovf_set", int'(ovf_o), 1);
    ready_lvl = 1'b1;
    run_until_done("backpressure", 300);
    repeat (2) cyc(1'b0, 1'b0);
    check("bp_outputs", n_out, 4);
    check("bp_ovf_sticky", int'(ovf_o), 1);

    // Abort mid-packet, then clean restart
    set_cfg(16, 1, 0); clear_stats();
    cyc(1'b1, 1'b0);
    k = 0;
    while (n_out < 5 && k < 300) begin cyc(1'b0, 1'b0); k++; end
    cyc(1'b0, 1'b1);
    check("abort_busy", int'(busy_o), 0);
    check("abort_valid", int'(pif.m_valid_o), 0);
    repeat (5) cyc(1'b0, 1'b0);
    check("abort_no_done", n_done, 0);
    set_cfg(4, 3, 2); clear_stats();
    cyc(1'b1, 1'b0);
    k = 0;
    while (n_out < 5 && k < 300) begin cyc(1'b0, 1'b0); k++; end
    cyc(1'b0, 1'b1);
    check("abort_pkt_kept", int'(pkt_cnt_o), 1);
    cyc(1'b1, 1'b0);
    check("restart_pkt_cnt", int'(pkt_cnt_o), 0);
    run_until_done("restart", 500);
    repeat (2) cyc(1'b0, 1'b0);
    check("restart_pkt_final", int'(pkt_cnt_o), 3);

    // Boundaries
    set_cfg(0, 2, 0); clear_stats();
    cyc(1'b1, 1'b0);
    check("len0_idle", int'(busy_o), 0);
    set_cfg(5, 0, 0);
    cyc(1'b1, 1'b0);
    check("num0_idle", int'(busy_o), 0);
    set_cfg(1, 2, 0);
    cyc(1'b1, 1'b0);
    run_until_done("len1", 200);
    repeat (2) cyc(1'b0, 1'b0);
    check("len1_outputs", n_out, 2);
    check("len1_lasts", n_last, 2);
    check("len1_done", n_done, 1);
    set_cfg(4, 1, 0);
    cyc(1'b1, 1'b1);
    check("start_abort_idle", int'(busy_o), 0);

    // Randomised runs with random aborts, stray starts and mid-run cfg changes
    strobe_rand = 1'b1; ready_rand = 1'b1; trig_rand = 1'b1;
    for (int r = 0; r < 25; r++) begin
      set_cfg($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 4));
      cyc(1'b1, 1'b0);
      for (int c = 0; c < 400; c++) begin
        if (c == 10) set_cfg($urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 9));
        cyc($urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        if (!busy_o) break;
      end
      repeat (3) cyc(1'b0, 1'b0);
    end
    strobe_rand = 1'b0; ready_rand = 1'b0; trig_rand = 1'b0; ready_lvl = 1'b1;
    cyc(1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0);

    // Reset in the middle of a capture with overflow pending
    set_cfg(20, 1, 0); trig_i = 1'b1; clear_stats();
    cyc(1'b1, 1'b0);
    k = 0;
    while (n_out < 3 && k < 200) begin cyc(1'b0, 1'b0); k++; end
    ready_lvl = 1'b0;
    repeat (6) cyc(1'b0, 1'b0);
    check("pre_rst_ovf", int'(ovf_o), 1);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    ready_lvl = 1'b1;
    check("rst_mid_valid", int'(pif.m_valid_o), 0);
    check("rst_mid_last", int'(pif.m_last_o), 0);
    check("rst_mid_busy", int'(busy_o), 0);
    check("rst_mid_ovf", int'(ovf_o), 0);
    check("rst_mid_pkt", int'(pkt_cnt_o), 0);
    repeat (3) cyc(1'b0, 1'b0);
    check("queue_empty", expq.size(), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
